// File: rtl/tawas_regfile_mt.sv
// tawas_regfile_mt: multithreaded register file for the Tawas core.
//
// Holds NREGS registers of DW bits for each of NTHREADS hardware threads. A
// round-robin pointer (THREAD) selects the active thread; every read and every
// functional write addresses that thread. A small clear engine zeroes one
// thread's registers, one per cycle, independently of the active pointer.
//
// Ports:
//   CLK, RST                      clock; asynchronous active-high reset
//   ADV                           advance THREAD by one (wraps)
//   THREAD                        active-thread pointer
//   PC_STORE, PC / PC_RTN         write / read of register NREGS-1 (low AW bits)
//   EC_STORE, EC                  write of register 0
//   AU_RA_SEL/AU_RA, AU_RB_SEL/AU_RB,
//   LS_PTR_SEL/LS_PTR, LS_STORE_SEL/LS_STORE   combinational read ports
//   AU_RC_*, LS_PTR_UPD_*, LS_LOAD_*           write ports (valid/select/data)
//   CLR_REQ, CLR_THREAD           request zeroing of one thread
//   CLR_BUSY, CLR_ACK             clear in progress / one-cycle completion pulse
//   COLLIDE                       registered: >=2 write ports hit one register
module tawas_regfile_mt #(
    parameter int NTHREADS = 4,
    parameter int NREGS    = 8,
    parameter int DW       = 32,
    parameter int AW       = 24,
    localparam int TW      = $clog2(NTHREADS),
    localparam int RW      = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          ADV,
    output logic [TW-1:0] THREAD,

    input  logic          PC_STORE,
    input  logic [AW-1:0] PC,
    output logic [AW-1:0] PC_RTN,

    input  logic          EC_STORE,
    input  logic [DW-1:0] EC,

    input  logic [RW-1:0] AU_RA_SEL,
    input  logic [RW-1:0] AU_RB_SEL,
    input  logic [RW-1:0] LS_PTR_SEL,
    input  logic [RW-1:0] LS_STORE_SEL,
    output logic [DW-1:0] AU_RA,
    output logic [DW-1:0] AU_RB,
    output logic [DW-1:0] LS_PTR,
    output logic [DW-1:0] LS_STORE,

    input  logic          AU_RC_VLD,
    input  logic [RW-1:0] AU_RC_SEL,
    input  logic [DW-1:0] AU_RC,
    input  logic          LS_PTR_UPD_VLD,
    input  logic [RW-1:0] LS_PTR_UPD_SEL,
    input  logic [DW-1:0] LS_PTR_UPD,
    input  logic          LS_LOAD_VLD,
    input  logic [RW-1:0] LS_LOAD_SEL,
    input  logic [DW-1:0] LS_LOAD,

    input  logic          CLR_REQ,
    input  logic [TW-1:0] CLR_THREAD,
    output logic          CLR_BUSY,
    output logic          CLR_ACK,

    output logic          COLLIDE
);

    typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

    logic [DW-1:0] regs [NTHREADS][NREGS];
    logic [TW-1:0] thread_q;

    clr_state_e    clr_state_q;
    logic [TW-1:0] clr_thread_q;
    logic [RW-1:0] clr_idx_q;

    logic [NREGS-1:0] wr_en;
    logic [DW-1:0]    wr_data [NREGS];
    logic [2:0]       hit_cnt [NREGS];
    logic             collide_d;

    assign THREAD = thread_q;

    // Reads: combinational from the active thread, no bypass of pending writes.
    assign AU_RA    = regs[thread_q][AU_RA_SEL];
    assign AU_RB    = regs[thread_q][AU_RB_SEL];
    assign LS_PTR   = regs[thread_q][LS_PTR_SEL];
    assign LS_STORE = regs[thread_q][LS_STORE_SEL];
    assign PC_RTN   = regs[thread_q][NREGS-1][AW-1:0];

    // Per-register write decode. Ports are applied lowest priority first so
    // the highest-priority enabled port leaves its data last.
    always_comb begin
        collide_d = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            wr_en[r]   = 1'b0;
            wr_data[r] = '0;
            hit_cnt[r] = 3'd0;
            if (PC_STORE && r == NREGS - 1) begin
                wr_en[r]   = 1'b1;
                wr_data[r] = DW'(PC);
                hit_cnt[r] = hit_cnt[r] + 3'd1;
            end
            if (EC_STORE && r == 0) begin
                wr_en[r]   = 1'b1;
                wr_data[r] = EC;
                hit_cnt[r] = hit_cnt[r] + 3'd1;
            end
            if (AU_RC_VLD && AU_RC_SEL == RW'(r)) begin
                wr_en[r]   = 1'b1;
                wr_data[r] = AU_RC;
                hit_cnt[r] = hit_cnt[r] + 3'd1;
            end
            if (LS_PTR_UPD_VLD && LS_PTR_UPD_SEL == RW'(r)) begin
                wr_en[r]   = 1'b1;
                wr_data[r] = LS_PTR_UPD;
                hit_cnt[r] = hit_cnt[r] + 3'd1;
            end
            if (LS_LOAD_VLD && LS_LOAD_SEL == RW'(r)) begin
                wr_en[r]   = 1'b1;
                wr_data[r] = LS_LOAD;
                hit_cnt[r] = hit_cnt[r] + 3'd1;
            end
            if (hit_cnt[r] >= 3'd2) begin
                collide_d = 1'b1;
            end
        end
    end

    // Register storage. A clear write beats any functional write to the same
    // thread/register; the functional write targets the pre-advance thread.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int t = 0; t < NTHREADS; t++) begin
                for (int r = 0; r < NREGS; r++) begin
                    regs[t][r] <= '0;
                end
            end
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (clr_state_q == StClear && clr_thread_q == TW'(t) &&
                        clr_idx_q == RW'(r)) begin
                        regs[t][r] <= '0;
                    end else if (thread_q == TW'(t) && wr_en[r]) begin
                        regs[t][r] <= wr_data[r];
                    end
                end
            end
        end
    end

    // Active-thread pointer; NTHREADS is a power of two so the add wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            thread_q <= '0;
        end else if (ADV) begin
            thread_q <= thread_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COLLIDE <= 1'b0;
        end else begin
            COLLIDE <= collide_d;
        end
    end

    // Clear engine with registered BUSY/ACK. Requests outside StIdle are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_state_q  <= StIdle;
            clr_thread_q <= '0;
            clr_idx_q    <= '0;
            CLR_BUSY     <= 1'b0;
            CLR_ACK      <= 1'b0;
        end else begin
            unique case (clr_state_q)
                StIdle: begin
                    CLR_ACK <= 1'b0;
                    if (CLR_REQ) begin
                        clr_state_q  <= StClear;
                        clr_thread_q <= CLR_THREAD;
                        clr_idx_q    <= '0;
                        CLR_BUSY     <= 1'b1;
                    end
                end
                StClear: begin
                    clr_idx_q <= clr_idx_q + RW'(1);
                    if (clr_idx_q == RW'(NREGS - 1)) begin
                        clr_state_q <= StDone;
                        CLR_ACK     <= 1'b1;
                    end
                end
                StDone: begin
                    clr_state_q <= StIdle;
                    CLR_BUSY    <= 1'b0;
                    CLR_ACK     <= 1'b0;
                end
                default: begin
                    clr_state_q <= StIdle;
                    CLR_BUSY    <= 1'b0;
                    CLR_ACK     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tawas_regfile_mt.sv
// Directed bench for tawas_regfile_mt with default parameters
// (4 threads, 8 registers, 32-bit data, 24-bit PC).
module tb_tawas_regfile_mt;

    localparam int TW = 2;
    localparam int RW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ADV;
    logic [TW-1:0] THREAD;
    logic          PC_STORE;
    logic [23:0]   PC;
    logic [23:0]   PC_RTN;
    logic          EC_STORE;
    logic [31:0]   EC;
    logic [RW-1:0] AU_RA_SEL, AU_RB_SEL, LS_PTR_SEL, LS_STORE_SEL;
    logic [31:0]   AU_RA, AU_RB, LS_PTR, LS_STORE;
    logic          AU_RC_VLD, LS_PTR_UPD_VLD, LS_LOAD_VLD;
    logic [RW-1:0] AU_RC_SEL, LS_PTR_UPD_SEL, LS_LOAD_SEL;
    logic [31:0]   AU_RC, LS_PTR_UPD, LS_LOAD;
    logic          CLR_REQ;
    logic [TW-1:0] CLR_THREAD;
    logic          CLR_BUSY, CLR_ACK, COLLIDE;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;
    int ack_cnt;

    tawas_regfile_mt dut (
        .CLK           (CLK),
        .RST           (RST),
        .ADV           (ADV),
        .THREAD        (THREAD),
        .PC_STORE      (PC_STORE),
        .PC            (PC),
        .PC_RTN        (PC_RTN),
        .EC_STORE      (EC_STORE),
        .EC            (EC),
        .AU_RA_SEL     (AU_RA_SEL),
        .AU_RB_SEL     (AU_RB_SEL),
        .LS_PTR_SEL    (LS_PTR_SEL),
        .LS_STORE_SEL  (LS_STORE_SEL),
        .AU_RA         (AU_RA),
        .AU_RB         (AU_RB),
        .LS_PTR        (LS_PTR),
        .LS_STORE      (LS_STORE),
        .AU_RC_VLD     (AU_RC_VLD),
        .AU_RC_SEL     (AU_RC_SEL),
        .AU_RC         (AU_RC),
        .LS_PTR_UPD_VLD(LS_PTR_UPD_VLD),
        .LS_PTR_UPD_SEL(LS_PTR_UPD_SEL),
        .LS_PTR_UPD    (LS_PTR_UPD),
        .LS_LOAD_VLD   (LS_LOAD_VLD),
        .LS_LOAD_SEL   (LS_LOAD_SEL),
        .LS_LOAD       (LS_LOAD),
        .CLR_REQ       (CLR_REQ),
        .CLR_THREAD    (CLR_THREAD),
        .CLR_BUSY      (CLR_BUSY),
        .CLR_ACK       (CLR_ACK),
        .COLLIDE       (COLLIDE)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_chk(input string tag, input int sel, input logic [31:0] exp);
        AU_RA_SEL = RW'(sel);
        #1;
        check_eq(tag, AU_RA, exp);
    endtask

    task automatic goto_thread(input int t);
        for (int i = 0; i < 8; i++) begin
            if (THREAD == TW'(t)) break;
            ADV = 1'b1;
            tick();
            ADV = 1'b0;
        end
        check_eq("goto_thread", 32'(THREAD), 32'(t));
    endtask

    task automatic wr_au(input int sel, input logic [31:0] data);
        AU_RC_VLD = 1'b1;
        AU_RC_SEL = RW'(sel);
        AU_RC     = data;
        tick();
        AU_RC_VLD = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ADV = 1'b0;
        PC_STORE = 1'b0; PC = '0; EC_STORE = 1'b0; EC = '0;
        AU_RA_SEL = '0; AU_RB_SEL = '0; LS_PTR_SEL = '0; LS_STORE_SEL = '0;
        AU_RC_VLD = 1'b0; AU_RC_SEL = '0; AU_RC = '0;
        LS_PTR_UPD_VLD = 1'b0; LS_PTR_UPD_SEL = '0; LS_PTR_UPD = '0;
        LS_LOAD_VLD = 1'b0; LS_LOAD_SEL = '0; LS_LOAD = '0;
        CLR_REQ = 1'b0; CLR_THREAD = '0;

        // Reset state
        #2;
        check_eq("rst_thread", 32'(THREAD), 32'd0);
        check_eq("rst_busy", 32'(CLR_BUSY), 32'd0);
        check_eq("rst_ack", 32'(CLR_ACK), 32'd0);
        check_eq("rst_collide", 32'(COLLIDE), 32'd0);
        check_eq("rst_reg", AU_RA, 32'd0);
        ADV = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        check_eq("post_rst_hold", 32'(THREAD), 32'd0);

        // Thread pointer sequence
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("thread_seq", 32'(THREAD), 32'((i + 1) % 4));
        end
        ADV = 1'b0;

        // Per-thread isolation, no bypass, write to pre-advance thread
        goto_thread(2);
        AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd3; AU_RC = 32'hDEADBEEF;
        rd_chk("no_bypass", 3, 32'd0);
        tick();
        AU_RC_VLD = 1'b0;
        rd_chk("t2_r3", 3, 32'hDEADBEEF);
        AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd4; AU_RC = 32'h44; ADV = 1'b1;
        tick();
        AU_RC_VLD = 1'b0; ADV = 1'b0;
        check_eq("adv_with_wr", 32'(THREAD), 32'd3);
        rd_chk("t3_r4", 4, 32'd0);
        rd_chk("t3_r3", 3, 32'd0);
        goto_thread(0);
        rd_chk("t0_r3", 3, 32'd0);
        goto_thread(1);
        rd_chk("t1_r3", 3, 32'd0);
        goto_thread(2);
        rd_chk("t2_r3_back", 3, 32'hDEADBEEF);
        rd_chk("t2_r4", 4, 32'h44);

        // Write priority and collisions
        LS_LOAD_VLD = 1'b1; LS_LOAD_SEL = 3'd5; LS_LOAD = 32'h11;
        AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd5; AU_RC = 32'h22;
        LS_PTR_UPD_VLD = 1'b1; LS_PTR_UPD_SEL = 3'd1; LS_PTR_UPD = 32'h33;
        tick();
        LS_LOAD_VLD = 1'b0; AU_RC_VLD = 1'b0; LS_PTR_UPD_VLD = 1'b0;
        check_eq("collide_load_au", 32'(COLLIDE), 32'd1);
        rd_chk("prio_load", 5, 32'h11);
        AU_RB_SEL = 3'd1;
        #1;
        check_eq("distinct_ptr", AU_RB, 32'h33);
        tick();
        check_eq("collide_clears", 32'(COLLIDE), 32'd0);

        LS_PTR_UPD_VLD = 1'b1; LS_PTR_UPD_SEL = 3'd6; LS_PTR_UPD = 32'h66;
        AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd6; AU_RC = 32'h77;
        tick();
        LS_PTR_UPD_VLD = 1'b0; AU_RC_VLD = 1'b0;
        check_eq("collide_ptr_au", 32'(COLLIDE), 32'd1);
        rd_chk("prio_ptr", 6, 32'h66);

        AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd0; AU_RC = 32'hA0;
        EC_STORE = 1'b1; EC = 32'hE0;
        tick();
        AU_RC_VLD = 1'b0; EC_STORE = 1'b0;
        check_eq("collide_au_ec", 32'(COLLIDE), 32'd1);
        rd_chk("prio_au_over_ec", 0, 32'hA0);

        PC_STORE = 1'b1; PC = 24'h123456;
        LS_LOAD_VLD = 1'b1; LS_LOAD_SEL = 3'd7; LS_LOAD = 32'h700;
        tick();
        PC_STORE = 1'b0; LS_LOAD_VLD = 1'b0;
        check_eq("collide_load_pc", 32'(COLLIDE), 32'd1);
        check_eq("prio_load_over_pc", 32'(PC_RTN), 32'h000700);

        // PC and EC stores together: distinct registers, no collision
        PC_STORE = 1'b1; PC = 24'hABCDEF;
        EC_STORE = 1'b1; EC = 32'h5;
        tick();
        PC_STORE = 1'b0; EC_STORE = 1'b0;
        check_eq("pc_ec_collide", 32'(COLLIDE), 32'd0);
        check_eq("pc_rtn", 32'(PC_RTN), 32'h00ABCDEF);
        rd_chk("pc_reg7", 7, 32'h00ABCDEF);
        rd_chk("ec_reg0", 0, 32'h5);

        // Clear of thread 1
        goto_thread(0);
        wr_au(1, 32'hAA);
        goto_thread(1);
        for (int r = 0; r < 8; r++) wr_au(r, 32'hFFFFFFFF);
        rd_chk("fill_r2", 2, 32'hFFFFFFFF);
        rd_chk("fill_r7", 7, 32'hFFFFFFFF);
        CLR_REQ = 1'b1; CLR_THREAD = 2'd1;
        tick();
        CLR_REQ = 1'b0;
        check_eq("clr_busy_start", 32'(CLR_BUSY), 32'd1);
        check_eq("clr_ack_start", 32'(CLR_ACK), 32'd0);
        busy_cnt = 1;
        ack_cnt  = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                CLR_REQ = 1'b1; CLR_THREAD = 2'd0;
            end
            if (k == 3) begin
                CLR_REQ = 1'b0;
                AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd2; AU_RC = 32'h1234;
            end
            tick();
            AU_RC_VLD = 1'b0;
            if (k == 3) check_eq("clr_vs_wr_collide", 32'(COLLIDE), 32'd0);
            if (k == 8) check_eq("clr_ack_9th", 32'(CLR_ACK), 32'd1);
            busy_cnt += int'(CLR_BUSY);
            ack_cnt  += int'(CLR_ACK);
        end
        check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd9);
        check_eq("clr_ack_cycles", 32'(ack_cnt), 32'd1);
        check_eq("clr_busy_end", 32'(CLR_BUSY), 32'd0);
        for (int r = 0; r < 8; r++) rd_chk("clr_t1_reg", r, 32'd0);
        goto_thread(0);
        rd_chk("clr_req_ignored", 1, 32'hAA);
        goto_thread(2);
        rd_chk("clr_other_thread", 5, 32'h11);

        // Reset during clear at index 4
        goto_thread(3);
        wr_au(4, 32'h55);
        wr_au(6, 32'h66);
        CLR_REQ = 1'b1; CLR_THREAD = 2'd3;
        tick();
        CLR_REQ = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        RST = 1'b1;
        #1;
        check_eq("abort_busy", 32'(CLR_BUSY), 32'd0);
        check_eq("abort_ack", 32'(CLR_ACK), 32'd0);
        check_eq("abort_thread", 32'(THREAD), 32'd0);
        rd_chk("abort_t0_r1", 1, 32'd0);
        tick();
        RST = 1'b0;
        busy_cnt = 0;
        ack_cnt  = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            busy_cnt += int'(CLR_BUSY);
            ack_cnt  += int'(CLR_ACK);
        end
        check_eq("abort_no_busy", 32'(busy_cnt), 32'd0);
        check_eq("abort_no_ack", 32'(ack_cnt), 32'd0);
        goto_thread(3);
        rd_chk("abort_t3_r4", 4, 32'd0);
        rd_chk("abort_t3_r6", 6, 32'd0);
        goto_thread(2);
        rd_chk("abort_t2_r5", 5, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tawas_regfile_mt.md
TAWAS_REGFILE_MT -- requirements
Module: tawas_regfile_mt

Interface
REQ-001 SHALL have parameter NTHREADS, default 4, meaning hardware thread count (power of 2, 2..16).
REQ-002 SHALL have parameter NREGS, default 8, meaning registers per thread (power of 2, 4..32).
REQ-003 SHALL have parameter DW, default 32, meaning register width; parameter AW, default 24, meaning PC width (AW<=DW).
REQ-004 SHALL have derived widths TW=clog2(NTHREADS) and RW=clog2(NREGS).
REQ-005 CLK  in  1  clock; RST  in  1  reset, asynchronous, active-high.
REQ-006 ADV  in  1  advance the active-thread pointer this cycle.
REQ-007 THREAD  out  TW  active-thread pointer; all reads and writes address this thread.
REQ-008 PC_STORE in 1, PC in AW  write zero-extended PC to register NREGS-1; PC_RTN out AW  low AW bits of register NREGS-1.
REQ-009 EC_STORE in 1, EC in DW  write EC to register 0.
REQ-010 AU_RA_SEL, AU_RB_SEL, LS_PTR_SEL, LS_STORE_SEL  in  RW each; AU_RA, AU_RB, LS_PTR, LS_STORE  out  DW each  read data.
REQ-011 AU_RC_VLD/AU_RC_SEL/AU_RC, LS_PTR_UPD_VLD/LS_PTR_UPD_SEL/LS_PTR_UPD, LS_LOAD_VLD/LS_LOAD_SEL/LS_LOAD  in  1/RW/DW  write ports.
REQ-012 CLR_REQ in 1, CLR_THREAD in TW  request zeroing of one thread; CLR_BUSY out 1; CLR_ACK out 1  completion pulse.
REQ-013 COLLIDE  out  1  registered flag: two or more enabled write ports hit the same register.

Function
REQ-014 THREAD SHALL increment by 1 modulo NTHREADS on each CLK edge with ADV=1 and hold otherwise; NTHREADS-1 wraps to 0.
REQ-015 Read outputs SHALL be combinational from the current THREAD's registers; no write-to-read bypass (written value visible the cycle after the edge).
REQ-016 Writes SHALL commit at the CLK edge to thread THREAD (value before any ADV increment at that edge).
REQ-017 Write priority per register, highest first: LS_LOAD, LS_PTR_UPD, AU_RC, EC_STORE, PC_STORE; lower-priority writes to the same register are discarded.
REQ-018 Writes to distinct registers in one cycle SHALL all commit.
REQ-019 COLLIDE SHALL be 1 for exactly the cycle after an edge at which >=2 enabled write ports (EC_STORE=reg 0, PC_STORE=reg NREGS-1 included) targeted the same register; 0 otherwise.
REQ-020 Clear FSM states: IDLE, CLEAR, DONE.
REQ-021 IDLE -> CLEAR on CLR_REQ=1; latch CLR_THREAD, index counter := 0.
REQ-022 CLEAR: each cycle write 0 to register[index] of the latched thread, index += 1; after index NREGS-1 -> DONE (NREGS cycles in CLEAR).
REQ-023 DONE: CLR_ACK=1 for one cycle, then -> IDLE; CLR_BUSY=1 in CLEAR and DONE, 0 in IDLE.
REQ-024 CLR_REQ while CLR_BUSY=1 SHALL be ignored (no queuing).
REQ-025 Clear write and functional write to the same thread/register in the same cycle: clear wins; functional write discarded, no COLLIDE.
REQ-026 Functional writes to other registers or threads during CLEAR SHALL commit normally.
REQ-027 Clear SHALL be independent of ADV and THREAD.

Reset
REQ-028 On RST=1 all NTHREADS*NREGS registers SHALL be 0, THREAD=0, FSM=IDLE, CLR_BUSY=0, CLR_ACK=0, COLLIDE=0, immediately and asynchronously.
REQ-029 RST asserted mid-clear SHALL abort the clear with no CLR_ACK; FSM returns to IDLE.
REQ-030 After RST deasserts, first state change SHALL occur at the next CLK edge.

Verification
REQ-031 Defaults; ADV=1 for 5 cycles from reset -> THREAD 1,2,3,0,1.
REQ-032 THREAD=2, AU_RC_VLD=1 sel 3 data 0xDEADBEEF, then ADV; return to thread 2 -> AU_RA(sel 3)=0xDEADBEEF; threads 0,1,3 reg 3 still 0.
REQ-033 Same edge: LS_LOAD sel 5=0x11, AU_RC sel 5=0x22, LS_PTR_UPD sel 1=0x33 -> reg5=0x11, reg1=0x33, COLLIDE=1 one cycle.
REQ-034 PC_STORE PC=0xABCDEF and EC_STORE EC=0x5 -> next cycle PC_RTN=0xABCDEF, reg7=0x00ABCDEF, reg0=0x5, COLLIDE=0.
REQ-035 Thread 1 fully 0xFFFFFFFF; CLR_REQ, CLR_THREAD=1 -> CLR_BUSY 9 cycles, CLR_ACK on 9th; all thread-1 regs 0; CLR_REQ during busy ignored; AU_RC to thread 1 reg 2 in same cycle as clear of reg 2 -> reg2=0.
REQ-036 RST pulse at clear index 4 -> all regs 0, CLR_BUSY=0, no CLR_ACK.
